calc_driver: RTL and testbench

CALC_DRIVER -- requirements
Module: calc_driver

---
 rtl/calc_driver.sv | 200 ++++++++++++++++++++
 tb/tb_calc_driver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_driver.sv
// rtl/calc_driver.sv - Request FIFO plus strobe sequencer driving an item/price calculator.
// Optional grand-total accumulator enabled by defining CALC_DRIVER_GRAND_TOTAL_EN.
module calc_driver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [639:0] req_item,
    input  logic [7:0]   req_qty,
    input  logic [15:0]  req_price,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [15:0]  resp_total,
    output logic         resp_err,
    output logic         calc_reset,
    output logic         calc_load,
    output logic         calc_equals,
    output logic [639:0] calc_item,
    output logic [7:0]   calc_qty,
    output logic [15:0]  calc_price,
    input  logic [15:0]  calc_total,
    input  logic         calc_err,
    output logic         busy
`ifdef CALC_DRIVER_GRAND_TOTAL_EN
    ,
    output logic [23:0]  grand_total
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_QUERY = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP
    } state_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [639:0] item;
        logic [7:0]   qty;
        logic [15:0]  price;
    } entry_t;

    entry_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    state_t          r_state;
    logic [1:0]      r_op;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_calc_reset;
    logic            r_calc_load;
    logic            r_calc_equals;
    logic [639:0]    r_calc_item;
    logic [7:0]      r_calc_qty;
    logic [15:0]     r_calc_price;
    logic            r_resp_valid;
    logic [15:0]     r_resp_total;
    logic            r_resp_err;

    logic            w_push;
    logic            w_pop;
    entry_t          w_head;
    entry_t          w_in;

    // Ready looks only at registered state so a pop in the same cycle never frees a slot early.
    assign req_ready = (r_state != S_INIT) && (r_count < CW'(FIFO_DEPTH));
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_in      = '{op: req_op, item: req_item, qty: req_qty, price: req_price};

    assign resp_valid  = r_resp_valid;
    assign resp_total  = r_resp_total;
    assign resp_err    = r_resp_err;
    assign calc_reset  = r_calc_reset;
    assign calc_load   = r_calc_load;
    assign calc_equals = r_calc_equals;
    assign calc_item   = r_calc_item;
    assign calc_qty    = r_calc_qty;
    assign calc_price  = r_calc_price;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CALC_DRIVER_GRAND_TOTAL_EN
    logic [23:0] r_grand_total;
    logic [24:0] w_gt_sum;
    assign w_gt_sum    = {1'b0, r_grand_total} + {9'd0, r_resp_total};
    assign grand_total = r_grand_total;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grand_total <= '0;
        end else if (r_state == S_SETUP && r_op == OP_CLEAR) begin
            r_grand_total <= '0;
        end else if (r_state == S_RESP && resp_ready && !r_resp_err) begin
            r_grand_total <= w_gt_sum[24] ? 24'hFFFFFF : w_gt_sum[23:0];
        end
    end
`endif

    // Strobes are set on entry to STROBE and cleared on exit, so each is exactly one cycle wide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_INIT;
            r_op          <= 2'b11;
            r_hold_cnt    <= '0;
            r_calc_reset  <= 1'b1;
            r_calc_load   <= 1'b0;
            r_calc_equals <= 1'b0;
            r_calc_item   <= '0;
            r_calc_qty    <= '0;
            r_calc_price  <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_total  <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_calc_reset <= 1'b0;
                    r_state      <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_pop) begin
                        r_op         <= w_head.op;
                        r_calc_item  <= w_head.item;
                        r_calc_qty   <= w_head.qty;
                        r_calc_price <= w_head.price;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_calc_load   <= (r_op == OP_LOAD);
                    r_calc_equals <= (r_op == OP_QUERY);
                    r_calc_reset  <= (r_op == OP_CLEAR);
                    r_state       <= S_STROBE;
                end
                S_STROBE: begin
                    r_calc_load   <= 1'b0;
                    r_calc_equals <= 1'b0;
                    r_calc_reset  <= 1'b0;
                    r_hold_cnt    <= HW'(HOLD_CYCLES - 1);
                    r_state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        if (r_op == OP_QUERY) begin
                            r_resp_valid <= 1'b1;
                            r_resp_total <= calc_total;
                            r_resp_err   <= calc_err;
                            r_state      <= S_RESP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_driver.sv
// tb/tb_calc_driver.sv - Table-driven scoreboard bench for calc_driver with a small calculator model.
module tb_calc_driver;

    localparam int HOLD = 1;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_QUERY = 2'b01, OP_CLEAR = 2'b10, OP_NOP = 2'b11;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [1:0]   req_op;
    logic [639:0] req_item;
    logic [7:0]   req_qty;
    logic [15:0]  req_price;
    logic         resp_valid, resp_ready;
    logic [15:0]  resp_total;
    logic         resp_err;
    logic         calc_reset, calc_load, calc_equals;
    logic [639:0] calc_item;
    logic [7:0]   calc_qty;
    logic [15:0]  calc_price;
    logic [15:0]  calc_total;
    logic         calc_err;
    logic         busy;
`ifdef CALC_DRIVER_GRAND_TOTAL_EN
    logic [23:0]  grand_total;
`endif

    always #5 clk = ~clk;

    calc_driver #(.FIFO_DEPTH(4), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_item(req_item), .req_qty(req_qty), .req_price(req_price),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_total(resp_total), .resp_err(resp_err),
        .calc_reset(calc_reset), .calc_load(calc_load), .calc_equals(calc_equals),
        .calc_item(calc_item), .calc_qty(calc_qty), .calc_price(calc_price),
        .calc_total(calc_total), .calc_err(calc_err),
        .busy(busy)
`ifdef CALC_DRIVER_GRAND_TOTAL_EN
        , .grand_total(grand_total)
`endif
    );

    // Calculator model: a small item/price table; unknown items answer 9999 with err.
    logic [639:0] m_key   [8];
    logic [15:0]  m_price [8];
    int           m_n = 0;

    function automatic logic [16:0] calc_eval(input logic [639:0] item, input logic [7:0] qty);
        for (int k = 0; k < 8; k++) begin
            if (k < m_n && m_key[k] == item) return {1'b0, 16'(m_price[k] * qty)};
        end
        return {1'b1, 16'd9999};
    endfunction

    always @(posedge clk) begin
        if (calc_reset) begin
            m_n <= 0;
        end else if (calc_load) begin
            if (m_n < 8) begin
                m_key[m_n]   <= calc_item;
                m_price[m_n] <= calc_price;
                m_n          <= m_n + 1;
            end
        end else if (calc_equals) begin
            {calc_err, calc_total} <= calc_eval(calc_item, calc_qty);
        end
    end

    typedef struct {
        logic [1:0]   op;
        logic [639:0] item;
        logic [7:0]   qty;
        logic [15:0]  price;
        logic         has_resp;
        logic [15:0]  exp_total;
        logic         exp_err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          n_load = 0, n_eq = 0, n_rst = 0, strobe_viol = 0;
    logic [16:0] sb [$];
    vec_t        tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer with req_valid dropped.
    task automatic send(input vec_t v);
        int t;
        req_valid = 1'b1;
        req_op    = v.op;
        req_item  = v.item;
        req_qty   = v.qty;
        req_price = v.price;
        t = 0;
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 expected ready=1");
        end else begin
            if (v.has_resp) sb.push_back({v.exp_err, v.exp_total});
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((busy || sb.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got busy=%0d pending=%0d expected 0", busy, sb.size());
        end
    endtask

    task automatic set_rr(input logic v);
        @(posedge clk);
        #1 resp_ready = v;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [639:0] item, input int qty,
                                input int price, input logic has_resp, input int tot, input logic err);
        vec_t v;
        v.op = op; v.item = item; v.qty = 8'(qty); v.price = 16'(price);
        v.has_resp = has_resp; v.exp_total = 16'(tot); v.exp_err = err;
        return v;
    endfunction

    // Response monitor and strobe bookkeeping.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (int'(calc_load) + int'(calc_equals) + int'(calc_reset) > 1) strobe_viol++;
                if (calc_load)   n_load++;
                if (calc_equals) n_eq++;
                if (calc_reset)  n_rst++;
                if (resp_valid && resp_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL resp_unexpected got total=%0d err=%0d expected none", resp_total, resp_err);
                    end else begin
                        e = sb.pop_front();
                        if ({resp_err, resp_total} !== e) begin
                            errors++;
                            $display("FAIL resp_data got total=%0d err=%0d expected total=%0d err=%0d",
                                     resp_total, resp_err, e[15:0], e[16]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [639:0] apple, pear, kiwi, maxi;
        int lat, rec;
        apple = 640'("apple"); pear = 640'("pear"); kiwi = 640'("kiwi"); maxi = 640'("max");
        tbl[0]  = mk(OP_LOAD,  apple, 0, 125,   0, 0,     0);
        tbl[1]  = mk(OP_QUERY, apple, 3, 0,     1, 375,   0);
        tbl[2]  = mk(OP_QUERY, pear,  1, 0,     1, 9999,  1);
        tbl[3]  = mk(OP_NOP,   pear,  0, 0,     0, 0,     0);
        tbl[4]  = mk(OP_LOAD,  kiwi,  0, 40000, 0, 0,     0);
        tbl[5]  = mk(OP_QUERY, kiwi,  1, 0,     1, 40000, 0);
        tbl[6]  = mk(OP_QUERY, kiwi,  1, 0,     1, 40000, 0);
        tbl[7]  = mk(OP_QUERY, kiwi,  1, 0,     1, 40000, 0);
        tbl[8]  = mk(OP_QUERY, apple, 2, 0,     1, 250,   0);
        tbl[9]  = mk(OP_CLEAR, apple, 0, 0,     0, 0,     0);
        tbl[10] = mk(OP_QUERY, apple, 1, 0,     1, 9999,  1);

        reset = 1'b1; req_valid = 1'b0; req_op = 2'b11; req_item = '0; req_qty = '0; req_price = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_total", {resp_err, resp_total}, 0);
        chk("rst_calc_reset", calc_reset, 1);
        chk("rst_strobes", {calc_load, calc_equals}, 0);
        chk("rst_calc_data", {|calc_item, |calc_qty, |calc_price}, 0);
        chk("rst_busy", busy, 1);
`ifdef CALC_DRIVER_GRAND_TOTAL_EN
        chk("rst_grand_total", grand_total, 0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("init_calc_reset", calc_reset, 1);
        chk("init_req_ready", req_ready, 0);
        @(negedge clk);
        chk("post_init_calc_reset", calc_reset, 0);
        chk("post_init_req_ready", req_ready, 1);
        chk("post_init_busy", busy, 0);
        chk("init_reset_pulses", n_rst, 1);

        for (int i = 0; i < 9; i++) send(tbl[i]);
        wait_idle(500);
        chk("load_pulses", n_load, 2);
        chk("equals_pulses", n_eq, 6);
`ifdef CALC_DRIVER_GRAND_TOTAL_EN
        chk("grand_total_sum", grand_total, 120625);
`endif

        // FIFO fills while the first response is stalled; the stalled response must stay stable.
        set_rr(1'b0);
        send(mk(OP_QUERY, apple, 4, 0, 1, 500, 0));
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("query_latency", lat, 3 + HOLD);
        repeat (3) @(negedge clk);
        chk("stall_resp_valid", resp_valid, 1);
        chk("stall_resp_total", resp_total, 500);
        send(mk(OP_QUERY, kiwi,  1, 0, 1, 40000, 0));
        send(mk(OP_QUERY, apple, 1, 0, 1, 125,   0));
        send(mk(OP_QUERY, apple, 2, 0, 1, 250,   0));
        send(mk(OP_QUERY, apple, 5, 0, 1, 625,   0));
        chk("full_req_ready", req_ready, 0);
        chk("full_busy", busy, 1);
        set_rr(1'b1);
        send(mk(OP_QUERY, apple, 6, 0, 1, 750, 0));
        wait_idle(500);

        rec = n_rst;
        send(tbl[9]);
        wait_idle(100);
        chk("clear_reset_pulse", n_rst - rec, 1);
`ifdef CALC_DRIVER_GRAND_TOTAL_EN
        chk("clear_grand_total", grand_total, 0);
`endif
        send(tbl[10]);
        wait_idle(100);

`ifdef CALC_DRIVER_GRAND_TOTAL_EN
        send(mk(OP_LOAD, maxi, 0, 65535, 0, 0, 0));
        for (int i = 0; i < 260; i++) send(mk(OP_QUERY, maxi, 1, 0, 1, 65535, 0));
        wait_idle(4000);
        chk("grand_total_saturate", grand_total, 24'hFFFFFF);
`endif

        // Reset while a query sits in HOLD with a second request still queued.
        send(mk(OP_LOAD, apple, 0, 7, 0, 0, 0));
        wait_idle(100);
        send(mk(OP_QUERY, apple, 1, 0, 0, 0, 0));
        send(mk(OP_QUERY, apple, 2, 0, 0, 0, 0));
        lat = 0;
        while (!calc_equals && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_reach_equals", calc_equals, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_calc_reset", calc_reset, 1);
        chk("midrst_req_ready", req_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        rec = n_rst;
        repeat (10) @(negedge clk);
        chk("midrst_init_pulse", n_rst - rec, 1);
        chk("midrst_fifo_empty", {busy, req_ready}, 2'b01);
        chk("midrst_no_resp", resp_valid, 0);
`ifdef CALC_DRIVER_GRAND_TOTAL_EN
        chk("midrst_grand_total", grand_total, 0);
`endif

        chk("strobe_onehot", strobe_viol, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
